// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the two requester ports (CPU = port 0, DMA = port 1),
// the data-memory port and status of dm_arbiter.
//   slave  : seen by the arbiter (requests and mem_rdata in; acks, memory
//            strobes, busy and dbg_state out)
//   master : seen by the requesters / memory model (the mirror image)
// Handshake: a requester raises req with stable fields and holds them until
// it sees a one-cycle ack; ack is the only completion indication, err and
// rdata are meaningful only in the ack cycle.
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [1:0]  dma_size;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic        dma_err;
  logic [31:0] dma_rdata;

  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;
  logic [1:0]  dbg_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_err, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_size, dma_addr, dma_wdata,
    output dma_ack, dma_err, dma_rdata,
    output mem_en, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, dbg_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_err, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_size, dma_addr, dma_wdata,
    input  dma_ack, dma_err, dma_rdata,
    input  mem_en, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, dbg_state
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the CPU MEM stage (port 0)
// and a DMA engine (port 1). Each access runs IDLE -> ISSUE -> [WAIT] -> RESP;
// misaligned or illegal-size requests skip memory and go IDLE -> RESP with err.
// Ports: clk, reset (async, active low), bus (dm_arbiter_if.slave).
// Parameters: LAT (read latency 1..7), STREAK_MAX (CPU grants allowed while
// DMA waits before DMA is forced).
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
module dm_arbiter #(
  parameter int LAT        = 2,
  parameter int STREAK_MAX = 2
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);
  localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic [2:0]    cnt;
  logic          id_r, we_r, err_r;
  logic [1:0]    size_r;
  logic [31:0]   addr_r, wdata_r, rdata_r;

  // Arbitration and selection of the winning request (used only in IDLE).
  logic        any_req, grant_dma;
  logic        sel_we, sel_mis;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  assign any_req   = bus.cpu_req | bus.dma_req;
  assign grant_dma = bus.dma_req & (~bus.cpu_req | (streak >= SW'(STREAK_MAX)));
  assign sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
  assign sel_size  = grant_dma ? bus.dma_size  : bus.cpu_size;
  assign sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign sel_mis   = (sel_size == 2'd3) ||
                     (sel_size == 2'd1 && sel_addr[0]) ||
                     (sel_size == 2'd2 && sel_addr[1:0] != 2'b00);

  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nx = sel_mis ? S_RESP : S_ISSUE;
          // Streak counts CPU wins that made a waiting DMA lose.
          if (grant_dma || !bus.dma_req) streak_nx = '0;
          else                           streak_nx = streak + SW'(1);
        end
      end
      S_ISSUE: state_nx = we_r ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 3'd0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      streak  <= '0;
      cnt     <= '0;
      id_r    <= 1'b0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      size_r  <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
      if (state == S_IDLE && any_req) begin
        id_r    <= grant_dma;
        we_r    <= sel_we;
        size_r  <= sel_size;
        addr_r  <= sel_addr;
        wdata_r <= sel_wdata;
        err_r   <= sel_mis;
        rdata_r <= '0;
      end
      if (state == S_ISSUE)     cnt <= 3'(LAT - 1);
      else if (state == S_WAIT) cnt <= cnt - 3'd1;
      // Read data is valid in the LAT-th cycle after ISSUE, i.e. when cnt hits 0.
      if (state == S_WAIT && cnt == 3'd0) rdata_r <= bus.mem_rdata;
    end
  end

  // Outputs are decoded from registered state only, so reset zeroes them at once.
  logic        mem_en, cpu_ack, dma_ack, cpu_err, dma_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, cpu_rdata, dma_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    cpu_err   = 1'b0;
    dma_err   = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    if (state == S_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = {addr_r[31:2], 2'b00};
      if (we_r) begin
        case (size_r)
          2'd0: begin
            mem_be    = 4'b0001 << addr_r[1:0];
            mem_wdata = {4{wdata_r[7:0]}};
          end
          2'd1: begin
            mem_be    = 4'b0011 << {addr_r[1], 1'b0};
            mem_wdata = {2{wdata_r[15:0]}};
          end
          2'd2: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_r;
          end
          default: ;
        endcase
      end
    end
    if (state == S_RESP) begin
      if (id_r) begin
        dma_ack   = 1'b1;
        dma_err   = err_r;
        dma_rdata = rdata_r;
      end else begin
        cpu_ack   = 1'b1;
        cpu_err   = err_r;
        cpu_rdata = rdata_r;
      end
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_be    = mem_be;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_err   = cpu_err;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign bus.dma_ack   = dma_ack;
  assign bus.dma_err   = dma_err;
  assign bus.dma_rdata = dma_rdata;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;
endmodule
